// File: rtl/control_pkg.sv
// Shared decode definitions: opcode map, ALU operation codes and the control
// word carried down the pipeline registers.
package control_pkg;

    localparam int OPCODE_W = 8;
    localparam int ALUOP_W  = 8;

    // Opcode map
    localparam logic [OPCODE_W-1:0] OP_ADD  = 8'h00;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 8'h01;
    localparam logic [OPCODE_W-1:0] OP_MUL  = 8'h02;
    localparam logic [OPCODE_W-1:0] OP_AND  = 8'h03;
    localparam logic [OPCODE_W-1:0] OP_OR   = 8'h04;
    localparam logic [OPCODE_W-1:0] OP_XOR  = 8'h05;
    localparam logic [OPCODE_W-1:0] OP_LDB  = 8'h10;
    localparam logic [OPCODE_W-1:0] OP_LDW  = 8'h11;
    localparam logic [OPCODE_W-1:0] OP_STB  = 8'h12;
    localparam logic [OPCODE_W-1:0] OP_STW  = 8'h13;
    localparam logic [OPCODE_W-1:0] OP_ADDI = 8'h14;
    localparam logic [OPCODE_W-1:0] OP_BEQ  = 8'h30;
    localparam logic [OPCODE_W-1:0] OP_JUMP = 8'h31;

    // ALU operation codes
    localparam logic [ALUOP_W-1:0] ALU_ADD = 8'h00;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 8'h01;
    localparam logic [ALUOP_W-1:0] ALU_MUL = 8'h02;
    localparam logic [ALUOP_W-1:0] ALU_AND = 8'h03;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 8'h04;
    localparam logic [ALUOP_W-1:0] ALU_XOR = 8'h05;

    // Control word; an all-zero value is a NOP (ADD, no writes, no memory access)
    typedef struct packed {
        logic                regDst;
        logic                branch;
        logic                memRead;
        logic                memToReg;
        logic                memWrite;
        logic                aluSrc;
        logic                regWrite;
        logic                memByte;
        logic                illegal;
        logic [ALUOP_W-1:0]  aluOp;
    } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Combinational main decoder: opcode -> control word. Anything not in the
// table, including unknown opcodes in simulation, falls to the illegal row,
// which never writes or touches memory.
module control_decode
    import control_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output ctrl_t               ctrl
);

    // Table lookup with the illegal row as the default
    always_comb begin
        ctrl         = '0;
        ctrl.illegal = 1'b1;
        case (opcode)
            OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR: begin
                ctrl.illegal  = 1'b0;
                ctrl.regDst   = 1'b1;
                ctrl.regWrite = 1'b1;
                // R-type opcodes map one-to-one onto ALU codes
                ctrl.aluOp    = opcode;
            end
            OP_LDB, OP_LDW: begin
                ctrl.illegal  = 1'b0;
                ctrl.memRead  = 1'b1;
                ctrl.memToReg = 1'b1;
                ctrl.aluSrc   = 1'b1;
                ctrl.regWrite = 1'b1;
                ctrl.memByte  = (opcode == OP_LDB);
                ctrl.aluOp    = ALU_ADD;
            end
            OP_STB, OP_STW: begin
                ctrl.illegal  = 1'b0;
                ctrl.memWrite = 1'b1;
                ctrl.aluSrc   = 1'b1;
                ctrl.memByte  = (opcode == OP_STB);
                ctrl.aluOp    = ALU_ADD;
            end
            OP_ADDI: begin
                ctrl.illegal  = 1'b0;
                ctrl.aluSrc   = 1'b1;
                ctrl.regWrite = 1'b1;
                ctrl.aluOp    = ALU_ADD;
            end
            OP_BEQ: begin
                // Compare is done as a subtract
                ctrl.illegal  = 1'b0;
                ctrl.branch   = 1'b1;
                ctrl.aluOp    = ALU_SUB;
            end
            OP_JUMP: begin
                ctrl.illegal  = 1'b0;
                ctrl.branch   = 1'b1;
                ctrl.aluSrc   = 1'b1;
                ctrl.aluOp    = ALU_ADD;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Main decoder with registered outputs: the opcode sampled at a rising edge
// drives the control outputs from that edge on. Reset clears to a NOP.
module control_unit
    import control_pkg::*;
#(
    parameter int OPCODE_W = control_pkg::OPCODE_W,
    parameter int ALUOP_W  = control_pkg::ALUOP_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                regDst,
    output logic                branch,
    output logic                memRead,
    output logic                memToReg,
    output logic [ALUOP_W-1:0]  aluOp,
    output logic                memWrite,
    output logic                aluSrc,
    output logic                regWrite,
    output logic                memByte,
    output logic                illegal
);

    ctrl_t ctrlNext;
    ctrl_t ctrlReg;

    control_decode uDecode (
        .opcode (opcode),
        .ctrl   (ctrlNext)
    );

    // Output register; asynchronous clear to the all-zero NOP word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrlReg <= '0;
        end else begin
            ctrlReg <= ctrlNext;
        end
    end

    assign regDst   = ctrlReg.regDst;
    assign branch   = ctrlReg.branch;
    assign memRead  = ctrlReg.memRead;
    assign memToReg = ctrlReg.memToReg;
    assign memWrite = ctrlReg.memWrite;
    assign aluSrc   = ctrlReg.aluSrc;
    assign regWrite = ctrlReg.regWrite;
    assign memByte  = ctrlReg.memByte;
    assign illegal  = ctrlReg.illegal;
    assign aluOp    = ctrlReg.aluOp;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: reset, decode rows, illegal opcodes,
// latency, asynchronous reset and a full opcode sweep with invariants.
module tb_control_unit;

    logic       clk;
    logic       rst_n;
    logic [7:0] opcode;
    logic       regDst, branch, memRead, memToReg, memWrite;
    logic       aluSrc, regWrite, memByte, illegal;
    logic [7:0] aluOp;

    int nCompared  = 0;
    int nMismatch  = 0;

    control_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .opcode   (opcode),
        .regDst   (regDst),
        .branch   (branch),
        .memRead  (memRead),
        .memToReg (memToReg),
        .aluOp    (aluOp),
        .memWrite (memWrite),
        .aluSrc   (aluSrc),
        .regWrite (regWrite),
        .memByte  (memByte),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed observation: {regDst,branch,memRead,memToReg,memWrite,aluSrc,regWrite,memByte,illegal,aluOp}
    function automatic logic [16:0] observed();
        return {regDst, branch, memRead, memToReg, memWrite, aluSrc,
                regWrite, memByte, illegal, aluOp};
    endfunction

    // Reference rows transcribed from the decode table
    function automatic logic [16:0] refRow(input logic [7:0] op);
        case (op)
            8'h00:   return {9'b1000_0010_0, 8'h00};
            8'h01:   return {9'b1000_0010_0, 8'h01};
            8'h02:   return {9'b1000_0010_0, 8'h02};
            8'h03:   return {9'b1000_0010_0, 8'h03};
            8'h04:   return {9'b1000_0010_0, 8'h04};
            8'h05:   return {9'b1000_0010_0, 8'h05};
            8'h10:   return {9'b0011_0111_0, 8'h00};
            8'h11:   return {9'b0011_0110_0, 8'h00};
            8'h12:   return {9'b0000_1101_0, 8'h00};
            8'h13:   return {9'b0000_1100_0, 8'h00};
            8'h14:   return {9'b0000_0110_0, 8'h00};
            8'h30:   return {9'b0100_0000_0, 8'h01};
            8'h31:   return {9'b0100_0100_0, 8'h00};
            default: return {9'b0000_0000_1, 8'h00};
        endcase
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nCompared++;
        if (obs !== expv) begin
            nMismatch++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Present an opcode between edges, then sample just after the next rising edge
    task automatic applyOp(input logic [7:0] op);
        @(negedge clk);
        opcode = op;
        @(posedge clk);
        #1;
        $display("op=0x%02h ctrl=0x%05h", op, observed());
    endtask

    task automatic checkInvariants(input string tag);
        checkVal({tag, "_rdwr"}, 32'(memRead & memWrite), 32'd0);
        checkVal({tag, "_m2r"},  32'(memToReg & ~memRead), 32'd0);
        checkVal({tag, "_brw"},  32'(branch & (regWrite | memWrite)), 32'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        opcode = 8'h01;
        repeat (3) @(posedge clk);
        #1;
        checkVal("reset_zero", 32'(observed()), 32'd0);

        // Release reset between edges; first decode happens at the next edge
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkVal("first_sub", 32'(observed()), {15'd0, 9'b1000_0010_0, 8'h01});

        applyOp(8'h11);
        checkVal("ldw", 32'(observed()), {15'd0, 9'b0011_0110_0, 8'h00});
        applyOp(8'h12);
        checkVal("stb", 32'(observed()), {15'd0, 9'b0000_1101_0, 8'h00});
        applyOp(8'h30);
        checkVal("beq", 32'(observed()), {15'd0, 9'b0100_0000_0, 8'h01});
        applyOp(8'h31);
        checkVal("jump", 32'(observed()), {15'd0, 9'b0100_0100_0, 8'h00});
        applyOp(8'h06);
        checkVal("ill_06", 32'(observed()), {15'd0, 9'b0000_0000_1, 8'h00});
        applyOp(8'h7F);
        checkVal("ill_7f", 32'(observed()), {15'd0, 9'b0000_0000_1, 8'h00});
        applyOp(8'hFF);
        checkVal("ill_ff", 32'(observed()), {15'd0, 9'b0000_0000_1, 8'h00});
        applyOp(8'h00);
        checkVal("add", 32'(observed()), {15'd0, 9'b1000_0010_0, 8'h00});

        // Mid-cycle opcode change must not reach the outputs before the edge
        @(negedge clk);
        opcode = 8'h13;
        #2;
        checkVal("latency_hold", 32'(observed()), {15'd0, 9'b1000_0010_0, 8'h00});
        @(posedge clk);
        #1;
        checkVal("latency_stw", 32'(observed()), {15'd0, 9'b0000_1100_0, 8'h00});

        // Reset pulse between edges clears at once; release alone decodes nothing
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 checkVal("async_clear", 32'(observed()), 32'd0);
        #1 rst_n = 1'b1;
        #1 checkVal("async_hold", 32'(observed()), 32'd0);
        @(posedge clk);
        #1;
        checkVal("after_release", 32'(observed()), {15'd0, 9'b0000_1100_0, 8'h00});

        // Full sweep against the reference table
        for (int i = 0; i < 256; i++) begin
            applyOp(8'(i));
            checkVal($sformatf("sweep_%02h", i), 32'(observed()), 32'(refRow(8'(i))));
            checkInvariants($sformatf("inv_%02h", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
